// File: rtl/truth_table_seq.sv
// Clocked sweep harness: drives every input vector to a gate function and packs the sampled
// outputs into per-output truth tables. Define TT_CHECK_EN to add the expected-table comparison.
module truth_table_seq #(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 2,
  parameter int SETTLE = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic [N_IN-1:0]              vec_out,
  input  logic [N_OUT-1:0]             dut_out,
  output logic [N_OUT*(2**N_IN)-1:0]   result,
  output logic                         busy,
  output logic                         done
`ifdef TT_CHECK_EN
  ,
  input  logic [N_OUT*(2**N_IN)-1:0]   expected,
  output logic                         mismatch,
  output logic [N_IN:0]                err_cnt
`endif
);

  localparam int VECS = 2 ** N_IN;
  localparam int RW   = N_OUT * VECS;
  localparam int CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [N_IN:0] LAST_VEC    = (N_IN + 1)'(VECS - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SAMPLE,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [N_IN:0]   vec_q, vec_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   result_q, result_d;

  logic [N_IN-1:0] vecLo;
  logic [VECS-1:0] vecSel;
  logic [RW-1:0]   captured;

  assign vecLo  = vec_q[N_IN-1:0];
  assign vecSel = {{(VECS - 1){1'b0}}, 1'b1} << vecLo;

`ifdef TT_CHECK_EN
  logic [RW-1:0]    exp_q, exp_d;
  logic             mismatch_q, mismatch_d;
  logic [N_IN:0]    err_q, err_d;
  logic [N_OUT-1:0] diffBits;
`endif

  // Each output owns a VECS-wide lane; the current vector's bit is overwritten with dut_out[k].
  for (genvar k = 0; k < N_OUT; k++) begin : g_lane
    logic [VECS-1:0] lane;
    assign lane = result_q[k*VECS +: VECS];
    assign captured[k*VECS +: VECS] = dut_out[k] ? (lane | vecSel) : (lane & ~vecSel);
`ifdef TT_CHECK_EN
    logic [VECS-1:0] expLane;
    assign expLane     = exp_q[k*VECS +: VECS];
    assign diffBits[k] = dut_out[k] ^ expLane[vecLo];
`endif
  end

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    result_d = result_q;
`ifdef TT_CHECK_EN
    exp_d      = exp_q;
    mismatch_d = mismatch_q;
    err_d      = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = WAIT;
          vec_d    = '0;
          cnt_d    = '0;
          result_d = '0;
`ifdef TT_CHECK_EN
          exp_d      = expected;
          mismatch_d = 1'b0;
          err_d      = '0;
`endif
        end
      end
      WAIT: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SAMPLE: begin
        result_d = captured;
`ifdef TT_CHECK_EN
        if (|diffBits) begin
          mismatch_d = 1'b1;
          err_d      = err_q + 1'b1;
        end
`endif
        if (vec_q == LAST_VEC) begin
          state_d = DONE;
        end else begin
          state_d = WAIT;
          vec_d   = vec_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        vec_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
`ifdef TT_CHECK_EN
      exp_q      <= '0;
      mismatch_q <= 1'b0;
      err_q      <= '0;
`endif
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
`ifdef TT_CHECK_EN
      exp_q      <= exp_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
`endif
    end
  end

  assign vec_out = vecLo;
  assign result  = result_q;
  assign busy    = (state_q == WAIT) || (state_q == SAMPLE);
  assign done    = (state_q == DONE);

`ifdef TT_CHECK_EN
  assign mismatch = mismatch_q;
  assign err_cnt  = err_q;
`endif

endmodule

// File: tb/tb_truth_table_seq.sv
// Scoreboard bench for truth_table_seq: one instance at SETTLE=1, one at SETTLE=3.
module tb_truth_table_seq;

  typedef struct {
    logic [15:0] res;
    int          busyLen;
  } exp_t;

  logic        clk;
  logic        rstA, startA, forceA;
  logic [2:0]  vecA;
  logic [1:0]  dutOutA;
  logic [15:0] resultA;
  logic        busyA, doneA;

  logic        rstB, startB;
  logic [2:0]  vecB;
  logic [1:0]  dutOutB;
  logic [15:0] resultB;
  logic        busyB, doneB;

`ifdef TT_CHECK_EN
  logic [15:0] expA, expB;
  logic        mismatchA, mismatchB;
  logic [3:0]  errA, errB;
`endif

  exp_t qA[$];
  exp_t qB[$];
  exp_t eA, eB;
  int   busyCntA, busyCntB;
  int   passCount, checkCount;

  // Gate functions under test: s1 = x | ~y, s2 = x & y & z (forceA kills s2 on A)
  assign dutOutA = {vecA[2] & vecA[1] & vecA[0] & ~forceA, vecA[2] | ~vecA[1]};
  assign dutOutB = {vecB[2] & vecB[1] & vecB[0], vecB[2] | ~vecB[1]};

  truth_table_seq #(.N_IN(3), .N_OUT(2), .SETTLE(1)) dutA (
    .clk     (clk),
    .rst     (rstA),
    .start   (startA),
    .vec_out (vecA),
    .dut_out (dutOutA),
    .result  (resultA),
    .busy    (busyA),
    .done    (doneA)
`ifdef TT_CHECK_EN
    ,
    .expected(expA),
    .mismatch(mismatchA),
    .err_cnt (errA)
`endif
  );

  truth_table_seq #(.N_IN(3), .N_OUT(2), .SETTLE(3)) dutB (
    .clk     (clk),
    .rst     (rstB),
    .start   (startB),
    .vec_out (vecB),
    .dut_out (dutOutB),
    .result  (resultB),
    .busy    (busyB),
    .done    (doneB)
`ifdef TT_CHECK_EN
    ,
    .expected(expB),
    .mismatch(mismatchB),
    .err_cnt (errB)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    else
      passCount++;
  endtask

  // Push the expected sweep outcome on A, then pulse start for one cycle.
  task automatic applyStimulus(input logic [15:0] res, input int busyLen);
    qA.push_back('{res, busyLen});
    @(negedge clk);
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
  endtask

  task automatic waitDoneA(input int limit);
    bit seen = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (doneA) begin
        seen = 1;
        break;
      end
    end
    checkOutput("A_done_seen", 64'(seen), 64'd1);
  endtask

  // Scoreboards: count busy cycles per sweep and compare against the queue on each done.
  always @(negedge clk) begin
    if (doneA) begin
      checkOutput("A_busy_in_done", 64'(busyA), 64'd0);
      if (qA.size() == 0) begin
        checkOutput("A_unexpected_done", 64'd1, 64'd0);
      end else begin
        eA = qA.pop_front();
        checkOutput("A_result", 64'(resultA), 64'(eA.res));
        checkOutput("A_busy_cycles", 64'(busyCntA), 64'(eA.busyLen));
      end
      busyCntA = 0;
    end else if (busyA) begin
      busyCntA++;
    end else begin
      busyCntA = 0;
    end
  end

  always @(negedge clk) begin
    if (doneB) begin
      if (qB.size() == 0) begin
        checkOutput("B_unexpected_done", 64'd1, 64'd0);
      end else begin
        eB = qB.pop_front();
        checkOutput("B_result", 64'(resultB), 64'(eB.res));
        checkOutput("B_busy_cycles", 64'(busyCntB), 64'(eB.busyLen));
      end
      busyCntB = 0;
    end else if (busyB) begin
      busyCntB++;
    end else begin
      busyCntB = 0;
    end
  end

  initial begin
    bit seen;
    passCount  = 0;
    checkCount = 0;
    busyCntA   = 0;
    busyCntB   = 0;
    rstA = 1'b1; startA = 1'b0; forceA = 1'b0;
    rstB = 1'b1; startB = 1'b0;
`ifdef TT_CHECK_EN
    expA = '0;
    expB = 16'h80F3;
`endif
    repeat (3) @(negedge clk);
    rstA = 1'b0;
    rstB = 1'b0;

    // Idle after reset with no start
    repeat (10) @(negedge clk);
    checkOutput("rst_busy", 64'(busyA), 64'd0);
    checkOutput("rst_done", 64'(doneA), 64'd0);
    checkOutput("rst_vec", 64'(vecA), 64'd0);
    checkOutput("rst_result", 64'(resultA), 64'd0);
    checkOutput("rstB_busy", 64'(busyB), 64'd0);
    checkOutput("rstB_result", 64'(resultB), 64'd0);
`ifdef TT_CHECK_EN
    checkOutput("rst_mismatch", 64'(mismatchA), 64'd0);
    checkOutput("rst_errcnt", 64'(errA), 64'd0);
`endif

    // Plain sweep at SETTLE=1
    applyStimulus(16'h80F3, 16);
    waitDoneA(40);
    @(negedge clk);
    checkOutput("after_done_vec", 64'(vecA), 64'd0);
    checkOutput("after_done_busy", 64'(busyA), 64'd0);
    checkOutput("after_done_done", 64'(doneA), 64'd0);
    checkOutput("after_done_result", 64'(resultA), 64'h80F3);

    // Sweep at SETTLE=3: 32 busy cycles
    qB.push_back('{16'h80F3, 32});
    @(negedge clk);
    startB = 1'b1;
    @(negedge clk);
    startB = 1'b0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (doneB) begin
        seen = 1;
        break;
      end
    end
    checkOutput("B_done_seen", 64'(seen), 64'd1);

    // start held high: no restart while busy or in DONE, restart from the following IDLE
    qA.push_back('{16'h80F3, 16});
    qA.push_back('{16'h80F3, 16});
    @(negedge clk);
    startA = 1'b1;
    waitDoneA(40);
    @(negedge clk);
    checkOutput("held_idle_busy", 64'(busyA), 64'd0);
    checkOutput("held_idle_vec", 64'(vecA), 64'd0);
    checkOutput("held_idle_result", 64'(resultA), 64'h80F3);
    @(negedge clk);
    checkOutput("held_restart_busy", 64'(busyA), 64'd1);
    checkOutput("held_restart_cleared", 64'(resultA), 64'd0);
    startA = 1'b0;
    waitDoneA(40);
    @(negedge clk);
    checkOutput("held_no_third", 64'(busyA), 64'd0);

    // Reset mid-sweep at vector 3: immediate abort, no done
    @(negedge clk);
    startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (vecA == 3'd3) begin
        seen = 1;
        break;
      end
    end
    checkOutput("abort_reached_vec3", 64'(seen), 64'd1);
    rstA = 1'b1;
    #1;
    checkOutput("abort_busy", 64'(busyA), 64'd0);
    checkOutput("abort_vec", 64'(vecA), 64'd0);
    checkOutput("abort_result", 64'(resultA), 64'd0);
    checkOutput("abort_done", 64'(doneA), 64'd0);
    @(negedge clk);
    rstA = 1'b0;
    repeat (20) @(negedge clk);
    applyStimulus(16'h80F3, 16);
    waitDoneA(40);

`ifdef TT_CHECK_EN
    // Faulty s2 on vector 7 only, then a clean sweep with expected changed after start
    forceA = 1'b1;
    expA   = 16'h80F3;
    applyStimulus(16'h00F3, 16);
    waitDoneA(40);
    @(negedge clk);
    checkOutput("chk_fault_mismatch", 64'(mismatchA), 64'd1);
    checkOutput("chk_fault_errcnt", 64'(errA), 64'd1);
    forceA = 1'b0;
    applyStimulus(16'h80F3, 16);
    expA = '0;
    waitDoneA(40);
    @(negedge clk);
    checkOutput("chk_clean_mismatch", 64'(mismatchA), 64'd0);
    checkOutput("chk_clean_errcnt", 64'(errA), 64'd0);
`endif

    repeat (3) @(negedge clk);
    checkOutput("A_queue_drained", 64'(qA.size()), 64'd0);
    checkOutput("B_queue_drained", 64'(qB.size()), 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
